// File: rtl/mtl_pkg.sv
// Default MTL panel raster timing and the sync bundle carried down the alignment pipe.
package mtl_pkg;
  localparam int DEF_H_SYNC   = 30;
  localparam int DEF_H_BACK   = 16;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 210;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BACK   = 20;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 22;
  localparam int DEF_PIPE_LAT = 2;
  localparam int MAX_PIPE_LAT = 8;

  function automatic int line_total(int sync, int back, int active, int front);
    return sync + back + active + front;
  endfunction

  localparam int H_TOTAL     = line_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT);
  localparam int V_TOTAL     = line_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACTIVE, DEF_V_FRONT);
  localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BACK;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0};
endpackage

// File: rtl/mtl_delay_line.sv
// Fixed-depth shift register for the sync bundle; depth 0 is a wire.
module mtl_delay_line
  import mtl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  iCLK,
  input  logic  iRSTN,
  input  sync_t iSYNC,
  output sync_t oSYNC
);
  if (DEPTH == 0) begin : g_thru
    assign oSYNC = iSYNC;
  end else begin : g_pipe
    sync_t sr [DEPTH];

    always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= SYNC_IDLE;
      end else begin
        sr[0] <= iSYNC;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign oSYNC = sr[DEPTH-1];
  end
endmodule

// File: rtl/mtl_timing_gen.sv
// MTL panel raster generator: issues pixel requests upstream and re-aligns the
// returned colour with sync/DE delayed by the source latency.
module mtl_timing_gen
  import mtl_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  output logic        oREQ,
  output logic [10:0] oX,
  output logic [9:0]  oY,
  output logic        oFRAME_START,
  output logic        oVBLANK,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic        oHSD,
  output logic        oVSD,
  output logic        oDE,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB
);
  localparam int H_TOT = line_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOT = line_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  if (PIPE_LAT > MAX_PIPE_LAT || PIPE_LAT < 0) begin : g_bad_lat
    $error("mtl_timing_gen: PIPE_LAT must be 0..8");
  end
  if (H_TOT >= 2048 || V_TOT >= 1024) begin : g_bad_raster
    $error("mtl_timing_gen: raster too large for counter widths");
  end

  localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
  localparam logic [10:0] H_SYN_E = 11'(H_SYNC);
  localparam logic [10:0] H_ST    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0]  V_SYN_E = 10'(V_SYNC);
  localparam logic [9:0]  V_ST    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_act, v_act, pix_act;
  sync_t       sync_s1, sync_dl;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign h_act   = (h_cnt >= H_ST) && (h_cnt < H_END);
  assign v_act   = (v_cnt >= V_ST) && (v_cnt < V_END);
  assign pix_act = h_act && v_act;

  // Request stage: what the upstream source sees, and raw sync for the pipe.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      oREQ         <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oFRAME_START <= 1'b0;
      oVBLANK      <= 1'b1;
      sync_s1      <= SYNC_IDLE;
    end else begin
      oREQ         <= pix_act;
      oX           <= pix_act ? h_cnt - H_ST : '0;
      oY           <= pix_act ? v_cnt - V_ST : '0;
      oFRAME_START <= (h_cnt == '0) && (v_cnt == '0);
      oVBLANK      <= !v_act;
      sync_s1      <= '{hs_n: (h_cnt >= H_SYN_E), vs_n: (v_cnt >= V_SYN_E), de: pix_act};
    end
  end

  mtl_delay_line #(.DEPTH(PIPE_LAT)) u_dly (
    .iCLK  (iCLK),
    .iRSTN (iRSTN),
    .iSYNC (sync_s1),
    .oSYNC (sync_dl)
  );

  // Pin stage: colour arrives now, so sync and RGB launch together.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      oHSD <= 1'b1;
      oVSD <= 1'b1;
      oDE  <= 1'b0;
      oR   <= '0;
      oG   <= '0;
      oB   <= '0;
    end else begin
      oHSD <= sync_dl.hs_n;
      oVSD <= sync_dl.vs_n;
      oDE  <= sync_dl.de;
      oR   <= sync_dl.de ? iR : '0;
      oG   <= sync_dl.de ? iG : '0;
      oB   <= sync_dl.de ? iB : '0;
    end
  end
endmodule
